// File: rtl/pat_chk.sv
// Receive-side checker for the wrap-around 0..LIM count pattern: self-synchronises,
// then counts out-of-sequence words while locked and drops lock after a run of misses.
module pat_chk #(
  parameter int IO_SIZE_G  = 4,
  parameter int LIM        = 14,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic                 vld_i,
  input  logic [IO_SIZE_G-1:0] dat_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic                 err_flag_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int RUN_W = (LOCK_CNT   < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int BAD_W = (UNLOCK_CNT < 2) ? 1 : $clog2(UNLOCK_CNT + 1);
  localparam logic [IO_SIZE_G-1:0] LIM_V    = IO_SIZE_G'(LIM);
  localparam logic [RUN_W-1:0]     LOCK_V   = RUN_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]     UNLOCK_V = BAD_W'(UNLOCK_CNT);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [IO_SIZE_G-1:0] exp_q, exp_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [BAD_W-1:0]     bad_q, bad_d;
  logic                 err_q, err_d;
  logic                 flag_q, flag_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 hit;
  logic                 match;
  logic [RUN_W-1:0]     run_inc;
  logic [BAD_W-1:0]     bad_inc;

  // Successor in the generator's sequence; out-of-range words simply wrap by truncation.
  function automatic logic [IO_SIZE_G-1:0] nxt(input logic [IO_SIZE_G-1:0] x);
    if (x == LIM_V) nxt = '0;
    else            nxt = x + IO_SIZE_G'(1);
  endfunction

  assign match   = (dat_i == exp_q);
  assign run_inc = run_q + RUN_W'(1);
  assign bad_inc = bad_q + BAD_W'(1);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    bad_d   = bad_q;
    hit     = 1'b0;
    if (vld_i) begin
      // Always resync to the received word so a single corruption costs one error.
      exp_d = nxt(dat_i);
      case (state_q)
        SEARCH: begin
          run_d = RUN_W'(1);
          if (LOCK_CNT == 1) begin
            state_d = LOCKED;
            bad_d   = '0;
          end else begin
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            run_d = run_inc;
            if (run_inc == LOCK_V) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            run_d = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            bad_d = '0;
          end else begin
            hit = 1'b1;
            if (bad_inc == UNLOCK_V) begin
              state_d = SEARCH;
              bad_d   = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // A mismatch landing in the same cycle as a clear survives as the first new error.
  always_comb begin
    err_d  = hit;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end
    if (hit) begin
      flag_d = 1'b1;
      if (clr_i)        cnt_d = ERR_CNT_W'(1);
      else if (~&cnt_q) cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SEARCH;
      exp_q   <= '0;
      run_q   <= '0;
      bad_q   <= '0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked_o   = (state_q == LOCKED);
  assign err_o      = err_q;
  assign err_flag_o = flag_q;
  assign err_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pat_chk.sv
// Directed bench for pat_chk: a default instance plus a 2-bit-counter instance
// sharing the same stimulus so saturation can be observed.
module tb_pat_chk;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       vld;
  logic [3:0] dat;

  logic        locked, err, flag;
  logic [15:0] cnt;
  logic        s_locked, s_err, s_flag;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  pat_chk u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .vld_i(vld), .dat_i(dat),
    .locked_o(locked), .err_o(err), .err_flag_o(flag), .err_cnt_o(cnt)
  );

  pat_chk #(.ERR_CNT_W(2)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .vld_i(vld), .dat_i(dat),
    .locked_o(s_locked), .err_o(s_err), .err_flag_o(s_flag), .err_cnt_o(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive on the falling edge, sample 1ns after the rising edge that consumes the inputs.
  task automatic step(input logic v, input logic [3:0] d, input logic c);
    @(negedge clk);
    vld = v;
    dat = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld   = 1'b0;
    clr   = 1'b0;
    dat   = 4'd0;
    #2;
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got %0b exp 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b exp 0", err); end
    checks++; if (flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_flag got %0b exp 0", flag); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock_wrap();
    logic [3:0] w;
    w = 4'd5;
    for (int i = 0; i < 13; i++) begin
      step(1'b1, w, 1'b0);
      checks++; if (locked !== (i >= 2)) begin errors++; $display("[TB] FAIL lock_wrap_locked word %0d got %0b exp %0b", w, locked, (i >= 2)); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL lock_wrap_err word %0d got %0b exp 0", w, err); end
      w = (w == 4'd14) ? 4'd0 : w + 4'd1;
    end
    checks++; if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL lock_wrap_cnt got %0d exp 0", cnt); end
  endtask

  task automatic test_single_injection();
    logic [3:0] words [6];
    logic       exp_err [6];
    words   = '{4'd3, 4'd4, 4'd5, 4'd15, 4'd0, 4'd1};
    exp_err = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, words[i], 1'b0);
      checks++; if (err !== exp_err[i]) begin errors++; $display("[TB] FAIL inject_err word %0d got %0b exp %0b", words[i], err, exp_err[i]); end
      checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL inject_locked word %0d got %0b exp 1", words[i], locked); end
    end
    checks++; if (cnt !== 16'd1) begin errors++; $display("[TB] FAIL inject_cnt got %0d exp 1", cnt); end
    checks++; if (flag !== 1'b1) begin errors++; $display("[TB] FAIL inject_flag got %0b exp 1", flag); end
  endtask

  task automatic test_loss_of_lock();
    logic [3:0] bad_words [4];
    logic [3:0] relock [3];
    bad_words = '{4'd3, 4'd9, 4'd3, 4'd9};
    relock    = '{4'd0, 4'd1, 4'd2};
    // Clear alone: counter and flag drop, lock untouched.
    step(1'b0, 4'd7, 1'b1);
    checks++; if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_alone_cnt got %0d exp 0", cnt); end
    checks++; if (flag !== 1'b0) begin errors++; $display("[TB] FAIL clr_alone_flag got %0b exp 0", flag); end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL clr_alone_locked got %0b exp 1", locked); end
    for (int w = 2; w <= 14; w++) begin
      step(1'b1, 4'(w), 1'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL loss_pre_err word %0d got %0b exp 0", w, err); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bad_words[i], 1'b0);
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL loss_err bad %0d got %0b exp 1", i, err); end
      checks++; if (cnt !== 16'(i + 1)) begin errors++; $display("[TB] FAIL loss_cnt bad %0d got %0d exp %0d", i, cnt, i + 1); end
      checks++; if (locked !== (i < 3)) begin errors++; $display("[TB] FAIL loss_locked bad %0d got %0b exp %0b", i, locked, (i < 3)); end
    end
    checks++; if (s_cnt !== 2'd3) begin errors++; $display("[TB] FAIL loss_sat_cnt got %0d exp 3", s_cnt); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, relock[i], 1'b0);
      checks++; if (locked !== (i == 2)) begin errors++; $display("[TB] FAIL relock_locked word %0d got %0b exp %0b", i, locked, (i == 2)); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL relock_err word %0d got %0b exp 0", i, err); end
    end
    checks++; if (cnt !== 16'd4) begin errors++; $display("[TB] FAIL relock_cnt got %0d exp 4", cnt); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL async_locked got %0b exp 0", locked); end
    checks++; if (flag !== 1'b0) begin errors++; $display("[TB] FAIL async_flag got %0b exp 0", flag); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL async_cnt got %0d exp 0", cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL async_err got %0b exp 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sparse_vld();
    logic [3:0] words [4];
    words = '{4'd2, 4'd7, 4'd8, 4'd9};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 1'b0);
      checks++; if (locked !== (i == 3)) begin errors++; $display("[TB] FAIL sparse_locked word %0d got %0b exp %0b", words[i], locked, (i == 3)); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL sparse_err word %0d got %0b exp 0", words[i], err); end
      for (int g = 0; g < 5; g++) step(1'b0, 4'(4'd3 + g), 1'b0);
      checks++; if (locked !== (i == 3)) begin errors++; $display("[TB] FAIL sparse_idle_locked word %0d got %0b exp %0b", words[i], locked, (i == 3)); end
    end
    checks++; if (cnt !== 16'd0) begin errors++; $display("[TB] FAIL sparse_cnt got %0d exp 0", cnt); end
  endtask

  task automatic test_saturation_clr();
    logic [3:0] words [11];
    words = '{4'd10, 4'd12, 4'd13, 4'd0, 4'd1, 4'd5, 4'd6, 4'd9, 4'd10, 4'd3, 4'd4};
    for (int i = 0; i < 11; i++) step(1'b1, words[i], 1'b0);
    checks++; if (s_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_cnt got %0d exp 3", s_cnt); end
    checks++; if (s_flag !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag got %0b exp 1", s_flag); end
    checks++; if (cnt !== 16'd5) begin errors++; $display("[TB] FAIL sat_wide_cnt got %0d exp 5", cnt); end
    checks++; if (s_locked !== 1'b1) begin errors++; $display("[TB] FAIL sat_locked got %0b exp 1", s_locked); end
    step(1'b1, 4'd8, 1'b1);
    checks++; if (s_cnt !== 2'd1) begin errors++; $display("[TB] FAIL clr_hit_cnt got %0d exp 1", s_cnt); end
    checks++; if (s_flag !== 1'b1) begin errors++; $display("[TB] FAIL clr_hit_flag got %0b exp 1", s_flag); end
    checks++; if (s_err !== 1'b1) begin errors++; $display("[TB] FAIL clr_hit_err got %0b exp 1", s_err); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("[TB] FAIL clr_hit_wide_cnt got %0d exp 1", cnt); end
    step(1'b0, 4'd0, 1'b1);
    checks++; if (s_cnt !== 2'd0) begin errors++; $display("[TB] FAIL clr_only_cnt got %0d exp 0", s_cnt); end
    checks++; if (s_flag !== 1'b0) begin errors++; $display("[TB] FAIL clr_only_flag got %0b exp 0", s_flag); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("[TB] FAIL clr_only_err got %0b exp 0", s_err); end
    checks++; if (s_locked !== 1'b1) begin errors++; $display("[TB] FAIL clr_only_locked got %0b exp 1", s_locked); end
    step(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lock_wrap();
    test_single_injection();
    test_loss_of_lock();
    test_async_reset();
    test_sparse_vld();
    test_saturation_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pat_chk.md
# pat_chk

Receive-side pattern checker paired with the free-running wrap-around pattern generator in the common TMR test fabric. It samples the generator's count word on each `vld_i` strobe and self-synchronises to the 0..LIM sequence. Once locked, it flags and counts every out-of-sequence word, including deliberately injected errors, and drops lock after a run of consecutive mismatches. Results go to the status/readout registers for TMR fault-injection campaigns.

## Interface
- `IO_SIZE_G`, 4: width of the checked data word.
- `LIM`, 14: last value of the sequence before wrap to 0; must be < 2^IO_SIZE_G.
- `LOCK_CNT`, 3: consecutive in-sequence words needed to declare lock; ≥ 1.
- `UNLOCK_CNT`, 4: consecutive mismatches while locked that force loss of lock; ≥ 1.
- `ERR_CNT_W`, 16: width of the error counter.

Ports:
- `clk_i` input 1: single clock; all state is on its rising edge.
- `rst_n_i` input 1: asynchronous, active-low reset.
- `clr_i` input 1: synchronous clear of the error counter and sticky flag. Does not affect lock.
- `vld_i` input 1: `dat_i` is sampled on this cycle; when low, all state holds.
- `dat_i` input IO_SIZE_G: received pattern word.
- `locked_o` output 1: checker is locked to the sequence.
- `err_o` output 1: one-cycle pulse per mismatch counted while locked.
- `err_flag_o` output 1: sticky; set on any counted error and cleared only by `clr_i` or reset.
- `err_cnt_o` output ERR_CNT_W: saturating count of errors.

## Operation
- Successor function: nxt(x) = 0 if x == LIM, else (x+1) truncated to IO_SIZE_G bits. Example: nxt(15) = 0 for 4-bit words. Out-of-range words are not special-cased.
- Internal registers:
  - `exp`: expected next word.
  - `run`: consecutive-match counter.
  - `bad`: consecutive-mismatch counter.
  - FSM state.
- FSM states: SEARCH, VERIFY, LOCKED.
- Every sampled word (`vld_i`=1) loads `exp` <= nxt(`dat_i`), whether it matched or not. This resync rule means one corrupted word costs exactly one error.
- SEARCH, on `vld_i`:
  - `run` <= 1.
  - Next state is LOCKED if LOCK_CNT == 1, else VERIFY.
- VERIFY, on `vld_i`:
  - Match (`dat_i` == `exp`): `run` <= `run`+1. When `run`+1 == LOCK_CNT, go to LOCKED.
  - Mismatch: `run` <= 1 and stay in VERIFY (restart from this word).
  - No errors are counted in VERIFY.
- LOCKED, on `vld_i`:
  - Match: `bad` <= 0.
  - Mismatch: `err_o` pulses, `err_flag_o` <= 1, `err_cnt_o` increments and saturates at all-ones, `bad` <= `bad`+1.
  - When `bad`+1 == UNLOCK_CNT on a mismatch: the error is still counted, then go to SEARCH with `bad` <= 0.
- On entry to LOCKED, `bad` <= 0.
- `clr_i`:
  - `err_cnt_o` <= 0 and `err_flag_o` <= 0.
  - If a counted mismatch occurs in the same cycle, that error is kept: `err_cnt_o` <= 1 and `err_flag_o` <= 1.
  - `err_o` still pulses.
- `locked_o` = 1 exactly when the state is LOCKED.

## Timing
- Reset values (async assert, sync-to-clock deassert handled upstream):
  - State SEARCH; `exp`, `run`, `bad` = 0.
  - `locked_o`=0, `err_o`=0, `err_flag_o`=0, `err_cnt_o`=0.
- All outputs are registered. An effect caused by the word sampled at edge N is visible after edge N.
- `err_o` is high for exactly the cycle following the offending sample edge. Back-to-back mismatches produce back-to-back pulses.
- `locked_o` rises after the edge that samples the LOCK_CNT-th consecutive in-sequence word. With defaults, that is the 3rd word, counting the SEARCH word as the 1st.
- `locked_o` falls after the edge sampling the UNLOCK_CNT-th consecutive mismatch. That mismatch is counted and pulses `err_o` in the same cycle.
- `vld_i` gaps of any length are transparent: no timeout, state holds.
- Reset mid-operation forces the reset values immediately; relock starts from SEARCH.

## Test plan
- Lock and wrap: after reset, drive 5,6,...,14,0,1,... with `vld_i`=1 every cycle.
  - `locked_o`=1 after the 3rd word.
  - `err_cnt_o`=0 across the 14->0 wrap.
  - `err_o` never pulses.
- Single injection: while locked, drive 5,15,0,1.
  - Exactly one `err_o` pulse, in the cycle after 15 is sampled.
  - `err_cnt_o`=1, `err_flag_o`=1, `locked_o` stays 1.
- Loss of lock: while locked, drive 4 consecutive wrong words (3,9,3,9 when 0 is expected).
  - 4 `err_o` pulses, `err_cnt_o`=4.
  - `locked_o`=0 after the 4th bad word.
  - A clean sequence then relocks after 3 words.
- Sparse `vld_i` and unlocked mismatches: in SEARCH/VERIFY, drive 2,7,8,9 with 5 idle cycles between words.
  - `err_cnt_o` stays 0.
  - Lock occurs after the word 9.
- `clr_i` collision and saturation: set `ERR_CNT_W`=2 and force 5 locked errors.
  - `err_cnt_o` saturates at 3.
  - Assert `clr_i` together with a mismatch: `err_cnt_o`=1, `err_flag_o`=1.
  - Assert `clr_i` alone: counter and flag go to 0.
- Async reset: assert `rst_n_i` mid-lock, between clock edges.
  - All outputs reach their reset values without waiting for a clock edge.
